// File: rtl/spi_controller_seq.sv
// SPI controller that sequences multi-byte transactions: SCLK idles low, data launches on
// the rising edge and is sampled on the falling edge, MSB first, with a one-entry TX buffer.
module spi_controller_seq #(
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int CS_SETUP_CYCLES   = 2,
    parameter int CS_HOLD_CYCLES    = 2,
    parameter int CS_IDLE_CYCLES    = 2,
    parameter int COUNT_W           = 8
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic [COUNT_W-1:0] i_byte_count,
    input  logic [7:0]         i_tx_byte,
    input  logic               i_tx_dv,
    output logic               o_tx_ready,
    output logic               o_rx_dv,
    output logic [7:0]         o_rx_byte,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_spi_clk,
    output logic               o_spi_copi,
    input  logic               i_spi_cipo,
    output logic               o_spi_cs_n
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_IDLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        SHIFT   = 3'd2,
        WAIT_TX = 3'd3,
        HOLD    = 3'd4,
        GAP     = 3'd5
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         tx_shift;
    logic [6:0]         rx_shift;
    logic [7:0]         buf_data;
    logic               buf_full;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] loaded;
    logic [COUNT_W-1:0] left;
    logic               tx_ready;
    logic               accept;
    logic [7:0]         next_byte;

    // Handshake: a byte moves on i_tx_dv && o_tx_ready; o_tx_ready means the buffer is empty
    // and the host still owes bytes for this transaction.
    assign tx_ready   = o_busy && !buf_full && (loaded < count_q);
    assign o_tx_ready = tx_ready;
    assign accept     = i_tx_dv && tx_ready;
    // A buffered byte always wins; otherwise the byte being accepted this cycle is used directly.
    assign next_byte  = buf_full ? buf_data : i_tx_byte;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            buf_data   <= '0;
            buf_full   <= 1'b0;
            count_q    <= '0;
            loaded     <= '0;
            left       <= '0;
            o_rx_dv    <= 1'b0;
            o_rx_byte  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_spi_clk  <= 1'b0;
            o_spi_copi <= 1'b0;
            o_spi_cs_n <= 1'b1;
        end else begin
            o_done  <= 1'b0;
            o_rx_dv <= 1'b0;
            if (accept) begin
                buf_data <= i_tx_byte;
                buf_full <= 1'b1;
                loaded   <= loaded + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (i_start && (i_byte_count != '0)) begin
                        count_q    <= i_byte_count;
                        left       <= i_byte_count - COUNT_W'(1);
                        loaded     <= COUNT_W'(1);
                        tx_shift   <= i_tx_byte;
                        buf_full   <= 1'b0;
                        cnt        <= '0;
                        o_spi_cs_n <= 1'b0;
                        o_busy     <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt        <= '0;
                        bit_cnt    <= '0;
                        o_spi_clk  <= 1'b1;
                        o_spi_copi <= tx_shift[7];
                        tx_shift   <= {tx_shift[6:0], 1'b0};
                        state      <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt != HALF_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (o_spi_clk) begin
                            o_spi_clk <= 1'b0;
                            rx_shift  <= {rx_shift[5:0], i_spi_cipo};
                            if (bit_cnt == 3'd7) begin
                                o_rx_dv   <= 1'b1;
                                o_rx_byte <= {rx_shift, i_spi_cipo};
                            end
                        end else if (bit_cnt != 3'd7) begin
                            bit_cnt    <= bit_cnt + 1'b1;
                            o_spi_clk  <= 1'b1;
                            o_spi_copi <= tx_shift[7];
                            tx_shift   <= {tx_shift[6:0], 1'b0};
                        end else if (left == '0) begin
                            state <= HOLD;
                        end else if (buf_full) begin
                            bit_cnt    <= '0;
                            o_spi_clk  <= 1'b1;
                            o_spi_copi <= next_byte[7];
                            tx_shift   <= {next_byte[6:0], 1'b0};
                            buf_full   <= 1'b0;
                            left       <= left - 1'b1;
                        end else begin
                            // A byte accepted right now lands in the buffer and starts next cycle.
                            state <= WAIT_TX;
                        end
                    end
                end
                WAIT_TX: begin
                    if (buf_full || accept) begin
                        cnt        <= '0;
                        bit_cnt    <= '0;
                        o_spi_clk  <= 1'b1;
                        o_spi_copi <= next_byte[7];
                        tx_shift   <= {next_byte[6:0], 1'b0};
                        buf_full   <= 1'b0;
                        left       <= left - 1'b1;
                        state      <= SHIFT;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt        <= '0;
                        o_spi_cs_n <= 1'b1;
                        o_spi_copi <= 1'b0;
                        o_done     <= 1'b1;
                        state      <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt    <= '0;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller_seq.sv
// Bench for spi_controller_seq: an echoing SPI peripheral model, a transaction table and
// hand-written sequences for the cycle timeline, ignored commands and mid-byte reset.
module tb_spi_controller_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] byte_count = '0;
    logic [7:0] tx_byte = '0;
    logic       tx_dv = 1'b0;
    logic       tx_ready, rx_dv, busy, done, sclk, copi, cs_n, cipo;
    logic [7:0] rx_byte;

    logic       loopback = 1'b0;
    logic       p_cipo = 1'b0;
    logic [7:0] p_preload = '0;
    logic [7:0] p_tx = '0;
    logic [7:0] p_rx = '0;
    int         p_cnt = 0;

    logic [7:0] rx_exp_q[$];
    logic [7:0] periph_exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;

    typedef struct {
        int             count;
        logic [2:0][7:0] tx;
        logic [7:0]     preload;
        int             delay;
        logic [2:0][7:0] rx;
        int             spacing;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    assign cipo = loopback ? copi : p_cipo;

    spi_controller_seq dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_start      (start),
        .i_byte_count (byte_count),
        .i_tx_byte    (tx_byte),
        .i_tx_dv      (tx_dv),
        .o_tx_ready   (tx_ready),
        .o_rx_dv      (rx_dv),
        .o_rx_byte    (rx_byte),
        .o_busy       (busy),
        .o_done       (done),
        .o_spi_clk    (sclk),
        .o_spi_copi   (copi),
        .i_spi_cipo   (cipo),
        .o_spi_cs_n   (cs_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Peripheral: launches on SCLK rise, samples on fall, then echoes each received byte.
    always @(negedge cs_n) begin
        p_tx  = p_preload;
        p_cnt = 0;
    end

    always @(posedge sclk) begin
        if (!cs_n) begin
            p_cipo = p_tx[7];
            p_tx   = {p_tx[6:0], 1'b0};
        end
    end

    always @(negedge sclk) begin
        if (!cs_n) begin
            p_rx = {p_rx[6:0], copi};
            p_cnt++;
            if (p_cnt == 8) begin
                p_cnt = 0;
                p_tx  = p_rx;
                if (!loopback) begin
                    if (periph_exp_q.size() == 0) fail_now("periph_rx_unexpected");
                    else check("periph_rx", p_rx, periph_exp_q.pop_front());
                end
            end
        end
    end

    function automatic vec_t mk(int count, logic [7:0] t0, logic [7:0] t1, logic [7:0] t2,
                                logic [7:0] pre, int delay, logic [7:0] r0, logic [7:0] r1,
                                logic [7:0] r2, int spacing);
        vec_t v;
        v.count   = count;
        v.tx[0]   = t0;
        v.tx[1]   = t1;
        v.tx[2]   = t2;
        v.preload = pre;
        v.delay   = delay;
        v.rx[0]   = r0;
        v.rx[1]   = r1;
        v.rx[2]   = r2;
        v.spacing = spacing;
        return v;
    endfunction

    // Expected {cs_n, busy, sclk, copi, done, rx_dv, tx_ready} for a lone 0xA5 started at cycle 0.
    function automatic logic [6:0] timeline_exp(int c);
        logic [7:0] b;
        logic       e_cs_n, e_busy, e_sclk, e_copi, e_done, e_rxdv;
        int         k;
        b      = 8'hA5;
        e_cs_n = !(c >= 1 && c <= 36);
        e_busy = (c >= 1 && c <= 38);
        e_sclk = 1'b0;
        e_copi = 1'b0;
        if (c >= 3 && c <= 34) e_sclk = (((c - 3) % 4) < 2);
        if (c >= 3 && c <= 36) begin
            k = (c - 3) / 4;
            if (k > 7) k = 7;
            e_copi = b[7 - k];
        end
        e_done = (c == 37);
        e_rxdv = (c == 33);
        return {e_cs_n, e_busy, e_sclk, e_copi, e_done, e_rxdv, 1'b0};
    endfunction

    task automatic wait_idle(input string tag);
        int n;
        for (n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (!busy) break;
        end
        if (n >= 200) fail_now({tag, "_idle_timeout"});
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int cyc, next_idx, rx_cnt, done_cnt, last_rx, dv_at;
        bit fire;
        wait_idle(tag);
        loopback  = 1'b0;
        p_preload = v.preload;
        @(posedge clk);
        #1;
        start      = 1'b1;
        byte_count = 8'(v.count);
        tx_byte    = v.tx[0];
        periph_exp_q.push_back(v.tx[0]);
        rx_exp_q.push_back(v.rx[0]);
        next_idx = 1;
        rx_cnt   = 0;
        done_cnt = 0;
        last_rx  = -1;
        dv_at    = -1;
        for (cyc = 1; cyc < 2000; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            tx_dv = 1'b0;
            if (rx_dv) begin
                if (rx_exp_q.size() == 0) fail_now({tag, "_rx_unexpected"});
                else check({tag, "_rx_byte"}, rx_byte, rx_exp_q.pop_front());
                if (last_rx >= 0 && v.spacing > 0) check({tag, "_rx_spacing"}, cyc - last_rx, v.spacing);
                last_rx = cyc;
                rx_cnt++;
                if (v.delay > 0 && next_idx == rx_cnt && next_idx < v.count) dv_at = cyc + v.delay;
            end
            if (done) done_cnt++;
            if (next_idx < v.count) begin
                fire = (v.delay == 0) ? tx_ready : (cyc == dv_at);
                if (fire) begin
                    if (v.delay > 2) check({tag, "_wait_tx_lines"}, {cs_n, sclk}, 2'b00);
                    if (v.delay > 0) check({tag, "_tx_ready_at_dv"}, tx_ready, 1'b1);
                    tx_dv   = 1'b1;
                    tx_byte = v.tx[next_idx];
                    periph_exp_q.push_back(v.tx[next_idx]);
                    rx_exp_q.push_back(v.rx[next_idx]);
                    next_idx++;
                end
            end
            if (done_cnt > 0 && !busy) break;
        end
        tx_dv = 1'b0;
        if (cyc >= 2000) fail_now({tag, "_timeout"});
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_rx_count"}, rx_cnt, v.count);
        check({tag, "_rx_queue_left"}, rx_exp_q.size(), 0);
        check({tag, "_periph_queue_left"}, periph_exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_rx, saw_done;
        vecs[0] = mk(1, 8'h81, 8'h00, 8'h00, 8'h3C, 0, 8'h3C, 8'h00, 8'h00, 0);
        vecs[1] = mk(3, 8'h11, 8'h22, 8'h33, 8'h5A, 0, 8'h5A, 8'h11, 8'h22, 32);
        vecs[2] = mk(2, 8'hC3, 8'h7E, 8'h00, 8'h00, 12, 8'h00, 8'hC3, 8'h00, 43);
        vecs[3] = mk(2, 8'hF0, 8'h0F, 8'h00, 8'hFF, 1, 8'hFF, 8'hF0, 8'h00, 33);
        vecs[4] = mk(2, 8'h96, 8'h69, 8'h00, 8'hA1, 0, 8'hA1, 8'h96, 8'h00, 32);

        // Reset state
        #23;
        check("reset_outputs", {cs_n, sclk, copi, busy, done, rx_dv, tx_ready}, 7'b1000000);
        check("reset_rx_byte", rx_byte, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Cycle-exact single byte with loopback, plus ignored start and ignored tx_dv
        wait_idle("timeline");
        loopback = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b1;
        byte_count = 8'd1;
        tx_byte    = 8'hA5;
        rx_exp_q.push_back(8'hA5);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            tx_dv = 1'b0;
            check($sformatf("timeline_c%0d", c), {cs_n, busy, sclk, copi, done, rx_dv, tx_ready},
                  timeline_exp(c));
            if (rx_dv) begin
                if (rx_exp_q.size() == 0) fail_now("timeline_rx_unexpected");
                else check("timeline_rx_byte", rx_byte, rx_exp_q.pop_front());
            end
            if (c == 10) begin
                start      = 1'b1;
                byte_count = 8'd3;
                tx_byte    = 8'h5C;
            end
            if (c == 12) begin
                tx_dv   = 1'b1;
                tx_byte = 8'hFF;
            end
        end
        check("timeline_rx_hold", rx_byte, 8'hA5);
        check("timeline_rx_queue_left", rx_exp_q.size(), 0);
        loopback = 1'b0;

        // Start with count 0 is ignored
        @(posedge clk);
        #1;
        start      = 1'b1;
        byte_count = 8'd0;
        tx_byte    = 8'h77;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            check($sformatf("count0_idle_c%0d", c), {cs_n, busy, sclk, tx_ready}, 4'b1000);
        end

        // Table of transactions against the echoing peripheral
        for (int i = 0; i < 4; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a byte
        wait_idle("reset_mid");
        p_preload = 8'h33;
        @(posedge clk);
        #1;
        start      = 1'b1;
        byte_count = 8'd2;
        tx_byte    = 8'hAA;
        saw_rx     = 1'b0;
        saw_done   = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (rx_dv) saw_rx = 1'b1;
            if (done) saw_done = 1'b1;
        end
        check("reset_mid_sclk_before", sclk, 1'b1);
        rst_n = 1'b0;
        #1;
        check("reset_mid_lines", {cs_n, sclk, busy, tx_ready, copi}, 5'b10000);
        check("reset_mid_rx_byte", rx_byte, 8'h00);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (rx_dv) saw_rx = 1'b1;
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (rx_dv) saw_rx = 1'b1;
            if (done) saw_done = 1'b1;
        end
        check("reset_mid_no_rx_dv", saw_rx, 1'b0);
        check("reset_mid_no_done", saw_done, 1'b0);
        check("reset_mid_stays_idle", {cs_n, busy}, 2'b10);
        rx_exp_q.delete();
        periph_exp_q.delete();
        run_txn(vecs[4], "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
